// File: rtl/tank_pkg.sv
// Shared definitions for the tank game blocks: heading codes, shell FSM
// states, map limits and the icon-centre offsets used for spawning.
package tank_pkg;

  localparam logic [2:0] HDG_N  = 3'b000;
  localparam logic [2:0] HDG_NE = 3'b001;
  localparam logic [2:0] HDG_E  = 3'b010;
  localparam logic [2:0] HDG_SE = 3'b011;
  localparam logic [2:0] HDG_S  = 3'b100;
  localparam logic [2:0] HDG_SW = 3'b101;
  localparam logic [2:0] HDG_W  = 3'b110;
  localparam logic [2:0] HDG_NW = 3'b111;

  localparam logic [7:0] MAP_MAX = 8'd127;
  localparam logic [7:0] ICON_CX = 8'd2;
  localparam logic [7:0] ICON_CY = 8'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FLY  = 2'd1,
    HIT  = 2'd2,
    COOL = 2'd3
  } shell_state_t;

  // 9-bit compare so lo + span cannot wrap for targets near the map edge.
  function automatic logic in_span(input logic [7:0] pos, input logic [7:0] lo,
                                   input logic [8:0] span);
    return ({1'b0, pos} >= {1'b0, lo}) && ({1'b0, pos} < ({1'b0, lo} + span));
  endfunction

endpackage

// File: rtl/shell_ctrl_if.sv
// Signal bundle between the game environment and the shell controller.
// Inputs are sampled on clk; outputs are registered, with no valid/ready
// handshake: tick and hit are single-cycle strobes, fire is a level.
interface shell_ctrl_if;
  logic       tick;
  logic       fire;
  logic [7:0] shoot_x;
  logic [7:0] shoot_y;
  logic [7:0] shoot_info;
  logic [7:0] tgt_x;
  logic [7:0] tgt_y;
  logic       burst;
  logic [7:0] shell_x;
  logic [7:0] shell_y;
  logic       shell_active;
  logic       hit;
  logic       ready;

  modport master (
    output tick, fire, shoot_x, shoot_y, shoot_info, tgt_x, tgt_y, burst,
    input  shell_x, shell_y, shell_active, hit, ready
  );

  modport slave (
    input  tick, fire, shoot_x, shoot_y, shoot_info, tgt_x, tgt_y, burst,
    output shell_x, shell_y, shell_active, hit, ready
  );
endinterface

// File: rtl/heading_step.sv
// Decodes a 3-bit heading into a signed unit step; north is y decreasing.
module heading_step
  import tank_pkg::*;
(
  input  logic [2:0]        hdg,
  output logic signed [1:0] dx,
  output logic signed [1:0] dy
);

  always_comb begin
    dx = 2'sb00;
    dy = 2'sb00;
    case (hdg)
      HDG_N:  begin dx = 2'sb00; dy = 2'sb11; end
      HDG_NE: begin dx = 2'sb01; dy = 2'sb11; end
      HDG_E:  begin dx = 2'sb01; dy = 2'sb00; end
      HDG_SE: begin dx = 2'sb01; dy = 2'sb01; end
      HDG_S:  begin dx = 2'sb00; dy = 2'sb01; end
      HDG_SW: begin dx = 2'sb11; dy = 2'sb01; end
      HDG_W:  begin dx = 2'sb11; dy = 2'sb00; end
      HDG_NW: begin dx = 2'sb11; dy = 2'sb11; end
      default: begin dx = 2'sb00; dy = 2'sb00; end
    endcase
  end

endmodule

// File: rtl/shell_ctrl.sv
// Projectile controller: launches a shell on a fire edge, steps it per tick
// along the latched heading and pulses hit on contact with the target box.
module shell_ctrl
  import tank_pkg::*;
#(
  parameter int RANGE    = 48,
  parameter int COOLDOWN = 16,
  parameter int HIT_W    = 4,
  parameter int HIT_H    = 8
) (
  input  logic         clk,
  input  logic         reset,
  shell_ctrl_if.slave  bus,
  output shell_state_t state_dbg
);

  localparam int SCW = (RANGE > 0)    ? $clog2(RANGE + 1)    : 1;
  localparam int CCW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;

  shell_state_t      state, state_nx;
  logic              fire_q, fire_req_q;
  logic [2:0]        hdg_q, hdg_nx;
  logic [7:0]        sx_q, sy_q, sx_nx, sy_nx;
  logic [SCW-1:0]    step_q, step_nx;
  logic [CCW-1:0]    cool_q, cool_nx;
  logic signed [1:0] dx, dy;
  logic signed [8:0] px, py;
  logic              off_map, collide;
  logic              active_q, hit_q, ready_q;

  heading_step u_heading_step (
    .hdg (hdg_q),
    .dx  (dx),
    .dy  (dy)
  );

  assign px = $signed({1'b0, sx_q}) + $signed({{7{dx[1]}}, dx});
  assign py = $signed({1'b0, sy_q}) + $signed({{7{dy[1]}}, dy});

  // px/py span -1..256: bit 8 flags negative (or 256), bit 7 flags 128..255.
  assign off_map = px[8] | px[7] | py[8] | py[7];
  assign collide = in_span(sx_q, bus.tgt_x, 9'(HIT_W)) &&
                   in_span(sy_q, bus.tgt_y, 9'(HIT_H));

  always_comb begin
    state_nx = state;
    hdg_nx   = hdg_q;
    sx_nx    = sx_q;
    sy_nx    = sy_q;
    step_nx  = step_q;
    cool_nx  = cool_q;
    case (state)
      IDLE: begin
        if (fire_req_q) begin
          state_nx = FLY;
          sx_nx    = bus.shoot_x + ICON_CX;
          sy_nx    = bus.shoot_y + ICON_CY;
          hdg_nx   = bus.shoot_info[2:0];
          step_nx  = SCW'(RANGE);
        end
      end
      FLY: begin
        if (collide && !bus.burst) begin
          state_nx = HIT;
        end else if (bus.tick) begin
          if ((step_q == '0) || off_map) begin
            state_nx = COOL;
            cool_nx  = CCW'(COOLDOWN);
          end else begin
            sx_nx   = px[7:0];
            sy_nx   = py[7:0];
            step_nx = step_q - SCW'(1);
          end
        end
      end
      HIT: begin
        state_nx = COOL;
        cool_nx  = CCW'(COOLDOWN);
      end
      COOL: begin
        if (cool_q == '0) begin
          state_nx = IDLE;
        end else if (bus.tick) begin
          cool_nx = cool_q - CCW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fire_q     <= 1'b0;
      fire_req_q <= 1'b0;
      hdg_q      <= '0;
      sx_q       <= '0;
      sy_q       <= '0;
      step_q     <= '0;
      cool_q     <= '0;
      active_q   <= 1'b0;
      hit_q      <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      state      <= state_nx;
      fire_q     <= bus.fire;
      fire_req_q <= bus.fire & ~fire_q;
      hdg_q      <= hdg_nx;
      sx_q       <= sx_nx;
      sy_q       <= sy_nx;
      step_q     <= step_nx;
      cool_q     <= cool_nx;
      // Flags are registered from the next state so they line up with it.
      active_q   <= (state_nx == FLY) || (state_nx == HIT);
      hit_q      <= (state_nx == HIT);
      ready_q    <= (state_nx == IDLE);
    end
  end

  assign bus.shell_x      = sx_q;
  assign bus.shell_y      = sy_q;
  assign bus.shell_active = active_q;
  assign bus.hit          = hit_q;
  assign bus.ready        = ready_q;
  assign state_dbg        = state;

endmodule
